capture_hold_bank: RTL
======================

CAPTURE_HOLD_BANK -- requirements
Module: capture_hold_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data bits per channel (legal range 1..32).
REQ-002 SHALL have parameter CHANNELS, default 4, meaning number of independent channels (legal range 1..16).
REQ-003 SHALL have port clock, input, 1, meaning single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset_bar, input, 1, meaning asynchronous, active-low reset.
REQ-005 SHALL have port data_in, input, CHANNELS*WIDTH, meaning channel k data in bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port enable, input, CHANNELS, meaning per-channel load request.
REQ-007 SHALL have port clear, input, CHANNELS, meaning per-channel synchronous clear.
REQ-008 SHALL have port rearm, input, CHANNELS, meaning per-channel one-shot rearm.
REQ-009 SHALL have port mode, input, 2, meaning global mode: 00 FOLLOW, 01 HOLD, 10 ONESHOT, 11 reserved (treated as HOLD).
REQ-010 SHALL have port q_out, output, CHANNELS*WIDTH, meaning registered held value per channel, same packing as data_in.
REQ-011 SHALL have port locked, output, CHANNELS, meaning channel is in LOCKED state.
REQ-012 SHALL have port changed, output, CHANNELS, meaning one-cycle pulse: q_out of that channel took a different value at the last edge.

Function
REQ-013 SHALL evaluate each channel independently per edge with priority clear > rearm > load.
REQ-014 SHALL, on clear[k], set q_out[k] to 0 and channel state to ARMED, regardless of mode.
REQ-015 SHALL, in FOLLOW, load data_in[k] into q_out[k] at the edge where enable[k]=1; otherwise hold; latency 1 clock.
REQ-016 SHALL, in HOLD or reserved mode, ignore enable and hold q_out.
REQ-017 SHALL, in ONESHOT, implement per-channel FSM ARMED/LOCKED: ARMED with enable=1 -> load data_in, go LOCKED; LOCKED ignores enable; rearm=1 -> ARMED without loading that edge.
REQ-018 SHALL force channel state to ARMED at every edge where mode is not ONESHOT; locked therefore deasserts one edge after leaving ONESHOT.
REQ-019 SHALL drive locked[k]=1 exactly when channel k state is LOCKED (registered).
REQ-020 SHALL register changed[k] <= (next q_out[k] != current q_out[k]); loading an identical value yields changed=0.
REQ-021 SHALL ignore rearm outside ONESHOT other than its priority over load (rearm=1 blocks load that edge in all modes).

Reset
REQ-022 SHALL, while reset_bar=0, immediately force q_out=0, locked=0, changed=0, all states ARMED, independent of clock.
REQ-023 SHALL resume normal operation at the first rising clock edge after reset_bar returns to 1; reset mid-operation discards LOCKED state.

Structure
REQ-024 SHALL place mode encodings (FOLLOW, HOLD, ONESHOT) and channel state encoding (ARMED, LOCKED) in shared package chb_pkg.
REQ-025 SHALL implement one channel in sub-module capture_hold_channel (parameter WIDTH), instantiated CHANNELS times via generate.

Verification (WIDTH=8, CHANNELS=4)
REQ-026 SHALL cover: reset_bar low mid-cycle with q_out nonzero -> q_out=0, locked=0, changed=0 before next edge.
REQ-027 SHALL cover: FOLLOW, enable[0]=1, data 0xA5 -> next edge q_out[7:0]=0xA5, changed[0]=1 for one cycle; reload 0xA5 -> changed[0]=0.
REQ-028 SHALL cover: HOLD, enable=4'hF, data all 0x3C -> q_out unchanged, changed=0.
REQ-029 SHALL cover: ONESHOT ch1, enable with 0x11 then 0x22 -> q_out[15:8]=0x11, locked[1]=1; rearm then enable 0x22 -> 0x22, locked[1]=1 again.
REQ-030 SHALL cover: ch2 holding 0x7E, clear+rearm+enable same edge, data 0x55 -> q_out[23:16]=0x00, ARMED, changed[2]=1.
REQ-031 SHALL cover: ch3 LOCKED, then reset pulse -> locked[3]=0; after release, enable with 0x99 in ONESHOT -> q_out[31:24]=0x99.

Source files
------------

// File: rtl/chb_pkg.sv
// Shared encodings for the capture/hold bank: global mode and per-channel state.
package chb_pkg;

  typedef enum logic [1:0] {
    MODE_FOLLOW  = 2'b00,
    MODE_HOLD    = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic {
    ST_ARMED  = 1'b0,
    ST_LOCKED = 1'b1
  } chan_state_e;

endpackage

// File: rtl/capture_hold_channel.sv
// One capture/hold channel: held register, one-shot ARMED/LOCKED FSM and change pulse.
//   state     | meaning
//   ST_ARMED  | next enable in ONESHOT captures data and locks
//   ST_LOCKED | value captured in ONESHOT; enable ignored until rearm or clear
module capture_hold_channel
  import chb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_bar,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             rearm,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] q_out,
  output logic             locked,
  output logic             changed
);

  mode_e            w_mode;
  chan_state_e      r_state;
  chan_state_e      w_state_next;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  logic             r_changed;

  assign w_mode = mode_e'(mode);

  // Priority clear > rearm > load; leaving ONESHOT always re-arms the channel.
  always_comb begin
    w_q_next     = r_q;
    w_state_next = r_state;
    if (clear) begin
      w_q_next     = '0;
      w_state_next = ST_ARMED;
    end else if (w_mode != MODE_ONESHOT) begin
      w_state_next = ST_ARMED;
      if (!rearm && enable && (w_mode == MODE_FOLLOW)) begin
        w_q_next = data_in;
      end
    end else if (rearm) begin
      w_state_next = ST_ARMED;
    end else if ((r_state == ST_ARMED) && enable) begin
      w_q_next     = data_in;
      w_state_next = ST_LOCKED;
    end
  end

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state   <= ST_ARMED;
      r_q       <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_q       <= w_q_next;
      r_changed <= (w_q_next != r_q);
    end
  end

  assign q_out   = r_q;
  assign locked  = (r_state == ST_LOCKED);
  assign changed = r_changed;

endmodule

// File: rtl/capture_hold_bank.sv
// Bank of independent capture/hold channels sharing one clock, reset and global mode.
module capture_hold_bank
  import chb_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input  logic                      clock,
  input  logic                      reset_bar,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       clear,
  input  logic [CHANNELS-1:0]       rearm,
  input  logic [1:0]                mode,
  output logic [CHANNELS*WIDTH-1:0] q_out,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS-1:0]       changed
);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    capture_hold_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clock     (clock),
      .reset_bar (reset_bar),
      .data_in   (data_in[k*WIDTH +: WIDTH]),
      .enable    (enable[k]),
      .clear     (clear[k]),
      .rearm     (rearm[k]),
      .mode      (mode),
      .q_out     (q_out[k*WIDTH +: WIDTH]),
      .locked    (locked[k]),
      .changed   (changed[k])
    );
  end

endmodule
